// File: rtl/inv_add_round_key_stage.sv
// ---------------------------------------------------------------------------
// inv_add_round_key_stage
//   AES-128 decryption: AddRoundKey followed by InvMixColumns. It sits after
//   the inverse S-box layer. It tracks the round index (9..0), fetches each
//   round key from an external key memory that has 1-cycle read latency, and
//   drives results on a valid/ready output. Round 0 skips InvMixColumns and
//   flags the plaintext with out_last.
//
// Optional feature macro: ROUND_TAG_EN (adds out_round, the key index applied)
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    upstream handshake; in_ready is high only in IDLE
//   in_state[127:0]      state after InvSubBytes, byte0 = [127:120]
//   in_first             beat is round 9 of a new block
//   key_rd, key_addr     key-memory read strobe and round-key index
//   key_data[127:0]      round key, valid the cycle after key_rd
//   out_valid/out_ready  downstream handshake
//   out_state[127:0]     result state, held until the handshake
//   out_last             result is plaintext (round 0)
//   err                  sticky: non-first beat arrived with no block open
//   out_round[3:0]       (ROUND_TAG_EN only) key index applied to out_state
// ---------------------------------------------------------------------------

// One 32-bit column through InvMixColumns. The top byte of the column is row 0.
module inv_mix_col (
    input  logic [31:0] col,
    output logic [31:0] res
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [3:0][7:0] x1, x2, x4, x8;
    logic [3:0][7:0] m9, mb, md, me;

    // x1[k] is row k of the column. This is the reverse of the packed index order.
    for (genvar k = 0; k < 4; k++) begin : g_mul
        assign x1[k] = col[31-8*k -: 8];
        assign x2[k] = xt(x1[k]);
        assign x4[k] = xt(x2[k]);
        assign x8[k] = xt(x4[k]);
        assign m9[k] = x8[k] ^ x1[k];
        assign mb[k] = x8[k] ^ x2[k] ^ x1[k];
        assign md[k] = x8[k] ^ x4[k] ^ x1[k];
        assign me[k] = x8[k] ^ x4[k] ^ x2[k];
    end

    // Row r of the matrix is {0e,0b,0d,09} rotated right by r.
    for (genvar r = 0; r < 4; r++) begin : g_row
        assign res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
endmodule

module inv_add_round_key_stage (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_first,
    output logic         key_rd,
    output logic [3:0]   key_addr,
    input  logic [127:0] key_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_last,
    output logic         err
`ifdef ROUND_TAG_EN
    ,
    output logic [3:0]   out_round
`endif
);
    localparam int          NUM_COLS = 4;
    localparam logic [3:0]  RND_NONE = 4'hF;
    localparam logic [3:0]  RND_TOP  = 4'd9;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    typedef struct packed {
        logic [127:0] st;
        logic [3:0]   idx;
    } beat_t;

    state_t state, nxt;
    beat_t  beat_q;
    logic [3:0] rnd;

    logic accept, legal, drop;
    logic [3:0] beat_idx;
    logic [127:0] t, mixed, res;
    logic [NUM_COLS-1:0][31:0] t_col, m_col;

    assign in_ready = (state == IDLE);
    assign key_rd   = (state == REQ);
    assign key_addr = beat_q.idx;

    assign accept   = in_valid & in_ready;
    // A first beat always restarts at round 9 and abandons any open block.
    assign beat_idx = in_first ? RND_TOP : rnd;
    assign legal    = accept & (in_first | (rnd != RND_NONE));
    assign drop     = accept & ~in_first & (rnd == RND_NONE);

    // key_data is only meaningful in WAIT. t is consumed only there.
    assign t     = beat_q.st ^ key_data;
    assign t_col = t;
    for (genvar i = 0; i < NUM_COLS; i++) begin : g_col
        inv_mix_col u_col (.col(t_col[i]), .res(m_col[i]));
    end
    assign mixed = m_col;
    assign res   = (beat_q.idx == 4'd0) ? t : mixed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (legal) nxt = REQ;
            REQ:     nxt = WAIT;
            WAIT:    nxt = HOLD;
            HOLD:    if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q    <= '0;
            rnd       <= RND_NONE;
            out_valid <= 1'b0;
            out_state <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (legal) begin
                beat_q.st  <= in_state;
                beat_q.idx <= beat_idx;
            end
            if (drop) err <= 1'b1;
            if (state == WAIT) begin
                out_state <= res;
                out_last  <= (beat_q.idx == 4'd0);
                out_valid <= 1'b1;
            end
            if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
                rnd       <= (beat_q.idx == 4'd0) ? RND_NONE : beat_q.idx - 4'd1;
            end
        end
    end

`ifdef ROUND_TAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              out_round <= 4'd0;
        else if (state == WAIT)  out_round <= beat_q.idx;
    end
`endif
endmodule

// File: tb/tb_inv_add_round_key_stage.sv
module tb_inv_add_round_key_stage;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         in_first = 1'b0;
    logic         key_rd;
    logic [3:0]   key_addr;
    logic [127:0] key_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_state;
    logic         out_last;
    logic         err;
`ifdef ROUND_TAG_EN
    logic [3:0]   out_round;
`endif

    inv_add_round_key_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_first(in_first),
        .key_rd(key_rd), .key_addr(key_addr), .key_data(key_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_last(out_last), .err(err)
`ifdef ROUND_TAG_EN
        , .out_round(out_round)
`endif
    );

    always #5 clk = ~clk;

    // key-schedule memory, 1-cycle read latency
    logic [127:0] keys [0:15];
    int rd_cnt = 0;
    logic [3:0] last_rd_addr = '0;
    always @(posedge clk) begin
        if (key_rd) begin
            key_data     <= keys[key_addr];
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= key_addr;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] mrnd = 4'hF;   // reference round tracker

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [7:0] base [4];
        logic [127:0] o = '0;
        logic [7:0] acc;
        base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(base[(k - r + 4) % 4], s[127-8*(4*c+k) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] expect_out(input logic [127:0] s, input logic [127:0] k,
                                                input logic [3:0] idx);
        return (idx == 4'd0) ? (s ^ k) : inv_mix(s ^ k);
    endfunction

    function automatic logic [3:0] next_rnd(input logic [3:0] idx);
        return (idx == 4'd0) ? 4'hF : idx - 4'd1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- drivers (start and end on a negedge) ----------------
    task automatic send(input logic [127:0] s, input logic f);
        in_valid = 1'b1; in_state = s; in_first = f;
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0;
    endtask

    task automatic wait_out(output bit ok, output int cyc);
        ok = 0; cyc = 0;
        for (int n = 0; n < 10; n++) begin
            if (out_valid) begin ok = 1; break; end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int ph = 0; ph < 2; ph++) begin
            n_cmp++;
            if ({in_ready, key_rd, key_addr, out_valid, out_last, err} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_ctrl ph%0d got rdy=%b rd=%b addr=%h ov=%b last=%b err=%b want 1 0 0 0 0 0",
                         ph, in_ready, key_rd, key_addr, out_valid, out_last, err);
            end
            n_cmp++;
            if (out_state !== 128'h0) begin n_bad++; $display("FAIL reset_state got %h want 0", out_state); end
`ifdef ROUND_TAG_EN
            n_cmp++;
            if (out_round !== 4'd0) begin n_bad++; $display("FAIL reset_round got %h want 0", out_round); end
`endif
            rst_n = 1'b1;
            @(negedge clk);
        end
        mrnd = 4'hF;
    endtask

    task automatic test_invmix();
        logic [127:0] s, w;
        bit ok; int cyc, c0;
        s = {4{32'h8e4da1bc}};
        w = {4{32'hdb135345}};
        keys[9] = '0;
        c0 = rd_cnt;
        send(s, 1'b1);
        n_cmp++;
        if ({key_rd, key_addr} !== {1'b1, 4'd9}) begin
            n_bad++; $display("FAIL invmix_req got rd=%b addr=%0d want rd=1 addr=9", key_rd, key_addr);
        end
        wait_out(ok, cyc);
        n_cmp++;
        if (!ok || cyc != 2) begin n_bad++; $display("FAIL invmix_latency got ok=%0d cyc=%0d want ok=1 cyc=2", ok, cyc); end
        n_cmp++;
        if (out_state !== w) begin n_bad++; $display("FAIL invmix_vector got %h want %h", out_state, w); end
        n_cmp++;
        if (out_state !== expect_out(s, keys[9], 4'd9)) begin
            n_bad++; $display("FAIL invmix_model got %h want %h", out_state, expect_out(s, keys[9], 4'd9));
        end
        n_cmp++;
        if (out_last !== 1'b0) begin n_bad++; $display("FAIL invmix_last got %b want 0", out_last); end
        n_cmp++;
        if (rd_cnt != c0 + 1) begin n_bad++; $display("FAIL invmix_rdcnt got %0d want %0d", rd_cnt - c0, 1); end
`ifdef ROUND_TAG_EN
        n_cmp++;
        if (out_round !== 4'd9) begin n_bad++; $display("FAIL invmix_round got %0d want 9", out_round); end
`endif
        finish_out();
        mrnd = 4'd8;
    endtask

    task automatic test_full_sequence();
        logic [127:0] s, e;
        logic [3:0] idx;
        bit ok; int cyc, c0;
        for (int k = 1; k < 10; k++) keys[k] = rnd128();
        keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
        for (int i = 0; i < 10; i++) begin
            s = (i == 9) ? 128'h00102030405060708090a0b0c0d0e0f0 : rnd128();
            idx = (i == 0) ? 4'd9 : mrnd;
            c0 = rd_cnt;
            send(s, i == 0);
            n_cmp++;
            if ({key_rd, key_addr} !== {1'b1, 4'(9 - i)}) begin
                n_bad++; $display("FAIL seq_addr beat%0d got rd=%b addr=%0d want rd=1 addr=%0d", i, key_rd, key_addr, 9 - i);
            end
            wait_out(ok, cyc);
            e = expect_out(s, keys[idx], idx);
            n_cmp++;
            if (!ok || out_state !== e) begin n_bad++; $display("FAIL seq_state beat%0d got %h want %h", i, out_state, e); end
            n_cmp++;
            if (out_last !== (i == 9)) begin n_bad++; $display("FAIL seq_last beat%0d got %b want %b", i, out_last, i == 9); end
            n_cmp++;
            if (rd_cnt != c0 + 1 || last_rd_addr !== idx) begin
                n_bad++; $display("FAIL seq_rd beat%0d got n=%0d addr=%0d want n=1 addr=%0d", i, rd_cnt - c0, last_rd_addr, idx);
            end
            finish_out();
            mrnd = next_rnd(idx);
        end
        n_cmp++;
        if (out_state !== 128'h00112233445566778899aabbccddeeff) begin
            n_bad++; $display("FAIL final_vector got %h want 00112233445566778899aabbccddeeff", out_state);
        end
    endtask

    // run right after the full sequence: a dropped beat also shows rnd went back to idle
    task automatic test_protocol_error();
        logic [127:0] s, e;
        bit ok; int cyc, c0;
        c0 = rd_cnt;
        send(rnd128(), 1'b0);
        n_cmp++;
        if ({err, in_ready} !== 2'b11) begin n_bad++; $display("FAIL perr_flag got err=%b rdy=%b want 1 1", err, in_ready); end
        for (int n = 0; n < 4; n++) begin
            n_cmp++;
            if ({out_valid, key_rd} !== 2'b00) begin
                n_bad++; $display("FAIL perr_quiet cyc%0d got ov=%b rd=%b want 0 0", n, out_valid, key_rd);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (rd_cnt != c0) begin n_bad++; $display("FAIL perr_rdcnt got %0d want 0", rd_cnt - c0); end
        s = rnd128();
        send(s, 1'b1);
        wait_out(ok, cyc);
        e = expect_out(s, keys[9], 4'd9);
        n_cmp++;
        if (!ok || out_state !== e) begin n_bad++; $display("FAIL perr_recover got %h want %h", out_state, e); end
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL perr_sticky got %b want 1", err); end
        finish_out();
        mrnd = 4'd8;
    endtask

    task automatic test_backpressure();
        logic [127:0] s, e;
        logic [3:0] idx;
        bit ok; int cyc, c1;
        out_ready = 1'b0;
        s = rnd128();
        idx = mrnd;
        send(s, 1'b0);
        wait_out(ok, cyc);
        e = expect_out(s, keys[idx], idx);
        c1 = rd_cnt;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL bp_valid got %b want 1", out_valid); end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, key_rd} !== 3'b100 || out_state !== e || out_last !== (idx == 0) || rd_cnt != c1) begin
                n_bad++;
                $display("FAIL bp_hold cyc%0d got ov=%b rdy=%b rd=%b st=%h last=%b n=%0d want 1 0 0 %h %b 0",
                         n, out_valid, in_ready, key_rd, out_state, out_last, rd_cnt - c1, e, idx == 0);
            end
        end
        finish_out();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_release got ov=%b rdy=%b want 0 1", out_valid, in_ready); end
        mrnd = next_rnd(idx);
    endtask

    task automatic test_back_to_back();
        logic [127:0] s, e;
        logic [3:0] idx;
        logic f;
        bit ok; int cyc, d;
        for (int k = 0; k < 10; k++) keys[k] = rnd128();
        for (int i = 0; i < 24; i++) begin
            f = (i == 0) || (mrnd == 4'hF) || ($urandom_range(0, 5) == 0);
            idx = f ? 4'd9 : mrnd;
            s = rnd128();
            d = $urandom_range(0, 2);
            out_ready = (d == 0);
            send(s, f);
            n_cmp++;
            if (key_addr !== idx) begin n_bad++; $display("FAIL b2b_addr beat%0d got %0d want %0d", i, key_addr, idx); end
            wait_out(ok, cyc);
            e = expect_out(s, keys[idx], idx);
            n_cmp++;
            if (!ok || cyc != 2 || out_state !== e || out_last !== (idx == 0)) begin
                n_bad++;
                $display("FAIL b2b_out beat%0d got cyc=%0d st=%h last=%b want cyc=2 st=%h last=%b",
                         i, cyc, out_state, out_last, e, idx == 0);
            end
            repeat (d) @(negedge clk);
            finish_out();
            mrnd = next_rnd(idx);
        end
    endtask

    task automatic test_reset_hold();
        bit ok; int cyc, c0;
        out_ready = 1'b0;
        send(rnd128(), 1'b1);
        wait_out(ok, cyc);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rsth_pre got ov=%b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_last, in_ready, key_rd, err} !== 5'b00100 || out_state !== 128'h0) begin
            n_bad++;
            $display("FAIL rsth_clear got ov=%b last=%b rdy=%b rd=%b err=%b st=%h want 0 0 1 0 0 0",
                     out_valid, out_last, in_ready, key_rd, err, out_state);
        end
`ifdef ROUND_TAG_EN
        n_cmp++;
        if (out_round !== 4'd0) begin n_bad++; $display("FAIL rsth_round got %0d want 0", out_round); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        mrnd = 4'hF;
        @(negedge clk);
        // rnd must be idle again: a non-first beat is dropped
        c0 = rd_cnt;
        send(rnd128(), 1'b0);
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || rd_cnt != c0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rsth_rnd got err=%b n=%0d ov=%b want 1 0 0", err, rd_cnt - c0, out_valid);
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) keys[k] = '0;
        @(negedge clk);
        test_reset();
        test_invmix();
        test_full_sequence();
        test_protocol_error();
        test_backpressure();
        test_back_to_back();
        test_reset_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t want finish before 200000", $time);
        $fatal(1, "watchdog");
    end
endmodule
